// File: rtl/rowwise_scale.sv
// Fixed-point types shared by the AFU datapath, followed by a two-stage streaming
// row scaler: multiply each element by a per-row scale, then shift and saturate.
package config_pkg;
    localparam int FixedPointPrecision = 16;
    localparam int FixedPointExponent  = -8;
    typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;
    localparam fixed_point_t FixedPointMax = {1'b0, {(FixedPointPrecision-1){1'b1}}};
    localparam fixed_point_t FixedPointMin = {1'b1, {(FixedPointPrecision-1){1'b0}}};
endpackage

module rowwise_scale
    import config_pkg::*;
#(
    parameter int RowLen = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic signed [FixedPointPrecision-1:0] scale_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic signed [FixedPointPrecision-1:0] in_data_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic signed [FixedPointPrecision-1:0] out_data_o,
    output logic                                  out_last_o,
    output logic                                  out_sat_o
);
    localparam int P    = FixedPointPrecision;
    localparam int E    = FixedPointExponent;
    localparam int PW   = 2 * P;
    localparam int ShL  = (E > 0) ? E : 0;
    localparam int ShR  = (E < 0) ? -E : 0;
    localparam int QW   = PW + ShL;
    localparam int IdxW = (RowLen > 1) ? $clog2(RowLen) : 1;
    localparam logic [IdxW-1:0]      LastIdx = IdxW'(RowLen - 1);
    localparam logic signed [QW-1:0] QMax    = QW'(FixedPointMax);
    localparam logic signed [QW-1:0] QMin    = QW'(FixedPointMin);

    logic                   en_s;
    logic                   accept_s;
    logic                   first_s;
    logic [IdxW-1:0]        idx_r;
    logic signed [P-1:0]    scale_q_r;
    logic signed [P-1:0]    scale_eff_s;
    logic signed [PW-1:0]   a_ext_s;
    logic signed [PW-1:0]   s_ext_s;
    logic signed [PW-1:0]   prod_s;
    logic                   s1_valid_r;
    logic                   s1_last_r;
    logic                   s1_zero_r;
    logic signed [PW-1:0]   s1_prod_r;
    logic signed [QW-1:0]   q_ext_s;
    logic signed [QW-1:0]   q_s;
    logic signed [P-1:0]    y_s;
    logic                   sat_s;

    // Global enable: the whole pipeline freezes while a result is refused downstream.
    always_comb begin
        en_s     = !(out_valid_o && !out_ready_i);
        accept_s = in_valid_i && en_s;
        first_s  = (idx_r == '0);
    end

    assign in_ready_o = en_s;

    // The first beat of a row multiplies by scale_i directly, later beats by the latched copy.
    always_comb begin
        if (first_s) begin
            scale_eff_s = scale_i;
        end else begin
            scale_eff_s = scale_q_r;
        end
        a_ext_s = PW'(in_data_i);
        s_ext_s = PW'(scale_eff_s);
        prod_s  = a_ext_s * s_ext_s;
    end

    // Row position counter and per-row scale latch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_r     <= '0;
            scale_q_r <= '0;
        end else if (accept_s) begin
            if (first_s) begin
                scale_q_r <= scale_i;
            end
            idx_r <= (idx_r == LastIdx) ? '0 : idx_r + IdxW'(1);
        end
    end

    // Stage 1: full-precision product with its framing tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_prod_r  <= '0;
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            s1_last_r  <= (idx_r == LastIdx);
            s1_zero_r  <= (in_data_i == '0) || (scale_eff_s == '0);
            s1_prod_r  <= prod_s;
        end
    end

    // Rescale by the binary exponent (arithmetic right shift floors) and clamp to range.
    always_comb begin
        q_ext_s = QW'(s1_prod_r);
        q_s     = (q_ext_s <<< ShL) >>> ShR;
        if (s1_zero_r) begin
            y_s   = '0;
            sat_s = 1'b0;
        end else if (q_s > QMax) begin
            y_s   = FixedPointMax;
            sat_s = 1'b1;
        end else if (q_s < QMin) begin
            y_s   = FixedPointMin;
            sat_s = 1'b1;
        end else begin
            y_s   = q_s[P-1:0];
            sat_s = 1'b0;
        end
    end

    // Stage 2: registered stream outputs, held while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_sat_o   <= 1'b0;
        end else if (en_s) begin
            out_valid_o <= s1_valid_r;
            out_data_o  <= y_s;
            out_last_o  <= s1_last_r;
            out_sat_o   <= sat_s;
        end
    end

endmodule

// File: tb/tb_rowwise_scale.sv
// Self-checking bench for rowwise_scale in Q8.8 with RowLen = 4, using a
// floor-divide-and-clamp reference model and an in-order expected-result queue.
module tb_rowwise_scale;
    localparam int RowLen = 4;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic signed [15:0] scale_i = '0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic signed [15:0] in_data_i = '0;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic signed [15:0] out_data_o;
    logic               out_last_o;
    logic               out_sat_o;

    rowwise_scale #(.RowLen(RowLen)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scale_i(scale_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_sat_o(out_sat_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int n_acc = 0;
    int m_idx = 0;
    int m_scale = 0;
    int exp_d[$];
    bit exp_l[$];
    bit exp_s[$];
    int log_d[$];
    bit log_l[$];
    bit log_s[$];
    int log_c[$];
    bit hold_v = 1'b0;
    logic signed [15:0] hold_d;
    logic hold_l;
    logic hold_s;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // y = floor(a*s / 2^8), clamped to the 16-bit signed range
    function automatic void ref_model(input int a, input int s, output int y, output bit sat);
        int prod;
        int q;
        prod = a * s;
        q = prod / 256;
        if (prod < 0 && (prod % 256) != 0) q = q - 1;
        if (q > 32767) begin
            y = 32767; sat = 1'b1;
        end else if (q < -32768) begin
            y = -32768; sat = 1'b1;
        end else begin
            y = q; sat = 1'b0;
        end
    endfunction

    task automatic clear_log();
        log_d.delete(); log_l.delete(); log_s.delete(); log_c.delete();
    endtask

    // One clock cycle: drive, check handshake rules, update model, advance.
    task automatic cycle(input bit v, input int a, input int s, input bit rdy);
        int y;
        bit sat;
        bit acc;
        int ed;
        bit el;
        bit es;
        in_valid_i  = v;
        in_data_i   = a[15:0];
        scale_i     = s[15:0];
        out_ready_i = rdy;
        #1;
        if (hold_v) begin
            chk("stall_valid", out_valid_o, 1);
            chk("stall_data", out_data_o, hold_d);
            chk("stall_last", out_last_o, hold_l);
            chk("stall_sat", out_sat_o, hold_s);
        end
        chk("in_ready", in_ready_o, !(out_valid_o && !rdy));
        acc = v && in_ready_o;
        if (acc) begin
            if (m_idx == 0) m_scale = s;
            ref_model(a, m_scale, y, sat);
            exp_d.push_back(y);
            exp_s.push_back(sat);
            exp_l.push_back(m_idx == RowLen - 1);
            m_idx = (m_idx + 1) % RowLen;
            n_acc++;
        end
        if (out_valid_o && rdy) begin
            if (exp_d.size() == 0) begin
                chk("unexpected_output", out_valid_o, 0);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                es = exp_s.pop_front();
                chk("out_data", out_data_o, ed);
                chk("out_last", out_last_o, el);
                chk("out_sat", out_sat_o, es);
                log_d.push_back(int'(out_data_o));
                log_l.push_back(out_last_o);
                log_s.push_back(out_sat_o);
                log_c.push_back(cyc);
            end
        end
        hold_v = out_valid_o && !rdy;
        hold_d = out_data_o;
        hold_l = out_last_o;
        hold_s = out_sat_o;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_d.size() != 0; i++) cycle(1'b0, 0, 0, 1'b1);
        chk("drain_empty", exp_d.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kd[12];
        bit ks[12];
        int s;
        kd = '{768, 32767, -32768, 0, -384, 300, -300, 255, -1, 0, -1, 1};
        ks = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_sat", out_sat_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Basic multiply with latency, then saturation and sign/rounding rows
        clear_log();
        cycle(1'b1, 384, 512, 1'b1);
        chk("lat_one_cycle", out_valid_o, 0);
        cycle(1'b0, 0, 0, 1'b1);
        chk("lat_two_cycles", out_valid_o, 1);
        chk("basic_data", out_data_o, 768);
        chk("basic_sat", out_sat_o, 0);
        cycle(1'b1, 25600, 999, 1'b1);
        cycle(1'b1, -25600, 7, 1'b1);
        cycle(1'b1, 0, 3, 1'b1);
        cycle(1'b1, -384, 256, 1'b1);
        cycle(1'b1, 300, 1, 1'b1);
        cycle(1'b1, -300, 1, 1'b1);
        cycle(1'b1, 255, 1, 1'b1);
        cycle(1'b1, -1, 128, 1'b1);
        cycle(1'b1, 1, 0, 1'b1);
        cycle(1'b1, -2, 0, 1'b1);
        cycle(1'b1, 3, 0, 1'b1);
        drain();
        chk("dir_count", log_d.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < log_d.size()) begin
                chk("dir_data", log_d[k], kd[k]);
                chk("dir_sat", log_s[k], ks[k]);
                chk("dir_last", log_l[k], (k % 4) == 3);
            end
        end

        // Row framing: two back-to-back rows, scale_i changing every cycle
        clear_log();
        for (int k = 0; k < 8; k++) begin
            s = (k == 0) ? 256 : (k == 4) ? 512 : int'($urandom_range(1, 4000));
            cycle(1'b1, (k % 4) + 1, s, 1'b1);
        end
        drain();
        chk("frame_count", log_d.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_d.size()) begin
                chk("frame_data", log_d[k], ((k % 4) + 1) * ((k < 4) ? 1 : 2));
                chk("frame_last", log_l[k], (k == 3) || (k == 7));
                if (k > 0) chk("frame_no_gap", log_c[k], log_c[k-1] + 1);
            end
        end

        // Backpressure with random traffic
        clear_log();
        n_acc = 0;
        for (int i = 0; i < 2000 && n_acc < 64; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 1023)) - 512,
                  $urandom_range(0, 1) == 1);
        end
        chk("bp_accepted", n_acc, 64);
        drain();
        chk("bp_count", log_d.size(), 64);

        // Reset mid-row with two results in flight
        clear_log();
        cycle(1'b1, 5, 256, 1'b1);
        cycle(1'b1, 6, 256, 1'b1);
        chk("inflight_valid", out_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_data", out_data_o, 0);
        chk("mid_rst_in_ready", in_ready_o, 1);
        exp_d.delete(); exp_l.delete(); exp_s.delete();
        m_idx = 0;
        hold_v = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = (k == 0) ? 768 : int'($urandom_range(1, 4000));
            cycle(1'b1, k + 1, s, 1'b1);
        end
        drain();
        chk("post_rst_count", log_d.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_d.size()) begin
                chk("post_rst_data", log_d[k], 3 * (k + 1));
                chk("post_rst_last", log_l[k], k == 3);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
